branch_resolve_ctrl: RTL and testbench

//  ID-stage branch controller for the pipelined MIPS core. Takes the decoded branch type and the

---
 rtl/mips_ctrl_pkg.sv | 28 ++
 rtl/br_cond_cmp.sv | 32 +++
 rtl/branch_resolve_ctrl.sv | 132 +++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared branch-control definitions: branch type codes, FSM states, helpers.
package mips_ctrl_pkg;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLEZ = 3'd3;
  localparam logic [2:0] BR_BGTZ = 3'd4;
  localparam logic [2:0] BR_BLTZ = 3'd5;
  localparam logic [2:0] BR_BGEZ = 3'd6;
  localparam logic [2:0] BR_RSVD = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } br_state_e;

  // Only the two-operand compares depend on rt.
  function automatic logic br_needs_rt(input logic [2:0] t);
    return (t == BR_BEQ) || (t == BR_BNE);
  endfunction

  // Codes 1..6 are real branches; 0 and the reserved 7 are treated as no branch.
  function automatic logic br_is_branch(input logic [2:0] t);
    return (t != BR_NONE) && (t != BR_RSVD);
  endfunction

endpackage

// File: rtl/br_cond_cmp.sv
// Branch condition evaluator: equality and sign compare of rs/rt.
module br_cond_cmp
  import mips_ctrl_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  br_type,
  output logic        taken,
  output logic        eq,
  output logic        ltz,
  output logic        eqz
);

  assign eq  = (a == b);
  assign ltz = a[31];
  assign eqz = (a == '0);

  // Select the condition for the decoded branch type.
  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_BEQ:  taken = eq;
      BR_BNE:  taken = ~eq;
      BR_BLEZ: taken = ltz | eqz;
      BR_BGTZ: taken = ~ltz & ~eqz;
      BR_BLTZ: taken = ltz;
      BR_BGEZ: taken = ~ltz;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch controller: operand-wait FSM, condition resolve,
// registered PC redirect and saturating branch/taken perf counters.
module branch_resolve_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned PERF_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [2:0]        id_br_type,
  input  logic [31:0]       id_pc,
  input  logic [15:0]       id_imm16,
  input  logic [31:0]       rs_val,
  input  logic [31:0]       rt_val,
  input  logic              rs_ready,
  input  logic              rt_ready,
  input  logic              flush,
  output logic              stall,
  output logic              redirect,
  output logic [31:0]       br_target,
  output logic              timeout_err,
  output logic [PERF_W-1:0] br_cnt,
  output logic [PERF_W-1:0] taken_cnt
);

  localparam int unsigned     WAIT_W    = $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  br_state_e         state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              is_br, ops_ok, taken, resolve, timeout_set;
  logic [31:0]       target;

  assign is_br  = id_valid & br_is_branch(id_br_type);
  assign ops_ok = rs_ready & (rt_ready | ~br_needs_rt(id_br_type));
  assign target = id_pc + 32'd4 + {{14{id_imm16[15]}}, id_imm16, 2'b00};

  br_cond_cmp u_cmp (
    .a       (rs_val),
    .b       (rt_val),
    .br_type (id_br_type),
    .taken   (taken),
    .eq      (),
    .ltz     (),
    .eqz     ()
  );

  // Next-state, wait counter, stall and resolve decisions; flush overrides all.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    stall        = 1'b0;
    resolve      = 1'b0;
    timeout_set  = 1'b0;
    if (flush) begin
      state_nxt    = ST_IDLE;
      wait_cnt_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_br) begin
            if (ops_ok) begin
              resolve = 1'b1;
            end else begin
              stall        = 1'b1;
              state_nxt    = ST_WAIT;
              wait_cnt_nxt = WAIT_W'(1);
            end
          end
        end
        ST_WAIT: begin
          if (ops_ok) begin
            resolve      = 1'b1;
            state_nxt    = ST_IDLE;
            wait_cnt_nxt = '0;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_set  = 1'b1;
            state_nxt    = ST_IDLE;
            wait_cnt_nxt = '0;
          end else begin
            stall        = 1'b1;
            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          state_nxt    = ST_IDLE;
          wait_cnt_nxt = '0;
        end
      endcase
    end
    // While reset is held nothing is pending, so the front end is never frozen.
    if (!reset) stall = 1'b0;
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Redirect pulse, target register and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redirect    <= 1'b0;
      br_target   <= '0;
      timeout_err <= 1'b0;
    end else begin
      redirect <= resolve & taken;
      if (resolve) br_target <= target;
      if (timeout_set) timeout_err <= 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else if (resolve) begin
      if (br_cnt != '1) br_cnt <= br_cnt + PERF_W'(1);
      if (taken && (taken_cnt != '1)) taken_cnt <= taken_cnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: vector table plus multi-cycle sequences.
module tb_branch_resolve_ctrl;
  import mips_ctrl_pkg::*;

  localparam int unsigned PERF_W = 4;
  localparam int unsigned SAT    = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [2:0]        id_br_type;
  logic [31:0]       id_pc;
  logic [15:0]       id_imm16;
  logic [31:0]       rs_val, rt_val;
  logic              rs_ready, rt_ready, flush;
  logic              stall, redirect, timeout_err;
  logic [31:0]       br_target;
  logic [PERF_W-1:0] br_cnt, taken_cnt;

  int checks = 0;
  int errors = 0;

  branch_resolve_ctrl #(.MAX_WAIT(16), .PERF_W(PERF_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_br_type  (id_br_type),
    .id_pc       (id_pc),
    .id_imm16    (id_imm16),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .rs_ready    (rs_ready),
    .rt_ready    (rt_ready),
    .flush       (flush),
    .stall       (stall),
    .redirect    (redirect),
    .br_target   (br_target),
    .timeout_err (timeout_err),
    .br_cnt      (br_cnt),
    .taken_cnt   (taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [2:0]  t;
    logic [31:0] pc;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        res;
    logic        red;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] pc,
                       input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                       input logic rsr, input logic rtr);
    id_valid = v; id_br_type = t; id_pc = pc; id_imm16 = imm;
    rs_val = rs; rt_val = rt; rs_ready = rsr; rt_ready = rtr;
  endtask

  task automatic do_reset();
    id_valid = 1'b0;
    flush    = 1'b0;
    reset    = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_br;
    int exp_tk;

    vecs[0]  = '{1'b1, BR_BEQ,  32'h0000_1000, 16'h0004, 32'd5,          32'd5, 1'b1, 1'b1, 32'h0000_1014};
    vecs[1]  = '{1'b1, BR_BNE,  32'h0000_2000, 16'hFFFF, 32'd7,          32'd7, 1'b1, 1'b0, 32'h0000_2000};
    vecs[2]  = '{1'b1, BR_BLEZ, 32'h0000_3000, 16'h0010, 32'd0,          32'd9, 1'b1, 1'b1, 32'h0000_3044};
    vecs[3]  = '{1'b1, BR_BGTZ, 32'h0000_4000, 16'h8000, 32'h8000_0000,  32'd0, 1'b1, 1'b0, 32'hFFFE_4004};
    vecs[4]  = '{1'b1, BR_BLTZ, 32'h0000_5000, 16'h0001, 32'hFFFF_FFFF,  32'd0, 1'b1, 1'b1, 32'h0000_5008};
    vecs[5]  = '{1'b1, BR_BGEZ, 32'h0000_6000, 16'h0002, 32'd0,          32'd0, 1'b1, 1'b1, 32'h0000_600C};
    vecs[6]  = '{1'b1, BR_NONE, 32'h0000_7000, 16'h0005, 32'd1,          32'd1, 1'b0, 1'b0, 32'h0000_600C};
    vecs[7]  = '{1'b1, BR_RSVD, 32'h0000_7100, 16'h0005, 32'd1,          32'd1, 1'b0, 1'b0, 32'h0000_600C};
    vecs[8]  = '{1'b1, BR_BGTZ, 32'hFFFF_FFFC, 16'h0000, 32'd1,          32'd0, 1'b1, 1'b1, 32'h0000_0000};
    vecs[9]  = '{1'b1, BR_BLEZ, 32'h0000_0100, 16'h7FFF, 32'h8000_0000,  32'd0, 1'b1, 1'b1, 32'h0002_0100};
    vecs[10] = '{1'b1, BR_BEQ,  32'h0000_0200, 16'h0003, 32'd1,          32'd2, 1'b1, 1'b0, 32'h0000_0210};
    vecs[11] = '{1'b1, BR_BNE,  32'h0000_0300, 16'h0000, 32'd1,          32'd2, 1'b1, 1'b1, 32'h0000_0304};
    vecs[12] = '{1'b1, BR_BGEZ, 32'h0000_0400, 16'h0001, 32'h8000_0000,  32'd0, 1'b1, 1'b0, 32'h0000_0408};
    vecs[13] = '{1'b1, BR_BLTZ, 32'h0000_0500, 16'h0001, 32'd0,          32'd0, 1'b1, 1'b0, 32'h0000_0508};
    vecs[14] = '{1'b0, BR_BEQ,  32'h0000_0600, 16'h0001, 32'd3,          32'd3, 1'b0, 1'b0, 32'h0000_0508};

    // Reset values
    drive(1'b0, BR_NONE, '0, '0, '0, '0, 1'b0, 1'b0);
    flush = 1'b0;
    reset = 1'b0;
    repeat (2) tick();
    chk("rst_stall",    32'(stall), 32'd0);
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_target",   br_target, 32'd0);
    chk("rst_timeout",  32'(timeout_err), 32'd0);
    chk("rst_br_cnt",   32'(br_cnt), 32'd0);
    chk("rst_taken",    32'(taken_cnt), 32'd0);
    reset = 1'b1;

    // Single-cycle resolves, applied back to back
    exp_br = 0;
    exp_tk = 0;
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].valid, vecs[i].t, vecs[i].pc, vecs[i].imm, vecs[i].rs, vecs[i].rt, 1'b1, 1'b1);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'd0);
      tick();
      if (vecs[i].res && exp_br < SAT) exp_br++;
      if (vecs[i].red && exp_tk < SAT) exp_tk++;
      chk($sformatf("v%0d_redirect", i), 32'(redirect), 32'(vecs[i].red));
      chk($sformatf("v%0d_target", i), br_target, vecs[i].tgt);
      chk($sformatf("v%0d_br_cnt", i), 32'(br_cnt), 32'(exp_br));
      chk($sformatf("v%0d_taken", i), 32'(taken_cnt), 32'(exp_tk));
    end

    // BEQ waits 3 cycles for rt
    do_reset();
    drive(1'b1, BR_BEQ, 32'h0000_0800, 16'h0002, 32'd9, 32'd9, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("A_stall%0d", i), 32'(stall), 32'd1);
      tick();
      chk($sformatf("A_noredir%0d", i), 32'(redirect), 32'd0);
    end
    rt_ready = 1'b1;
    #1;
    chk("A_stall_rel", 32'(stall), 32'd0);
    tick();
    chk("A_redirect", 32'(redirect), 32'd1);
    chk("A_target",   br_target, 32'h0000_080C);
    chk("A_br_cnt",   32'(br_cnt), 32'd1);
    chk("A_taken",    32'(taken_cnt), 32'd1);
    id_valid = 1'b0;
    tick();
    chk("A_pulse_end", 32'(redirect), 32'd0);

    // BGEZ with rs never ready: timeout
    do_reset();
    drive(1'b1, BR_BGEZ, 32'h0000_0A00, 16'h0001, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      #1;
      chk($sformatf("B_stall%0d", i), 32'(stall), 32'd1);
      tick();
    end
    #1;
    chk("B_to_stall",   32'(stall), 32'd0);
    chk("B_to_pending", 32'(timeout_err), 32'd0);
    tick();
    id_valid = 1'b0;
    #1;
    chk("B_timeout",  32'(timeout_err), 32'd1);
    chk("B_idle",     32'(stall), 32'd0);
    chk("B_noredir",  32'(redirect), 32'd0);
    chk("B_br_cnt",   32'(br_cnt), 32'd0);
    repeat (5) tick();
    chk("B_sticky",   32'(timeout_err), 32'd1);

    // Flush: a registered redirect still fires; flush beats ops_ok
    do_reset();
    drive(1'b1, BR_BNE, 32'h0000_0900, 16'h0000, 32'd1, 32'd2, 1'b1, 1'b1);
    tick();
    chk("C_redirect", 32'(redirect), 32'd1);
    chk("C_target",   br_target, 32'h0000_0904);
    flush = 1'b1;
    #1;
    chk("C_redir_flush", 32'(redirect), 32'd1);
    tick();
    chk("C_flush_nores", 32'(redirect), 32'd0);
    chk("C_flush_cnt",   32'(br_cnt), 32'd1);
    flush = 1'b0;
    drive(1'b1, BR_BEQ, 32'h0000_0B00, 16'h0001, 32'd3, 32'd3, 1'b1, 1'b0);
    repeat (2) tick();
    rt_ready = 1'b1;
    flush    = 1'b1;
    #1;
    chk("C_wflush_stall", 32'(stall), 32'd0);
    tick();
    chk("C_wflush_redir",  32'(redirect), 32'd0);
    chk("C_wflush_cnt",    32'(br_cnt), 32'd1);
    chk("C_wflush_target", br_target, 32'h0000_0904);
    flush    = 1'b0;
    id_valid = 1'b0;
    rt_ready = 1'b0;
    #1;
    chk("C_wflush_idle", 32'(stall), 32'd0);

    // Async reset mid-WAIT
    id_valid = 1'b1;
    tick();
    #1;
    chk("D_waiting", 32'(stall), 32'd1);
    reset = 1'b0;
    #1;
    chk("D_stall",    32'(stall), 32'd0);
    chk("D_target",   br_target, 32'd0);
    chk("D_br_cnt",   32'(br_cnt), 32'd0);
    chk("D_redirect", 32'(redirect), 32'd0);
    id_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("D_idle", 32'(stall), 32'd0);

    // Counter saturation with PERF_W=4
    do_reset();
    drive(1'b1, BR_BEQ, 32'h0000_0D00, 16'h0001, 32'd4, 32'd4, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 9) chk("E_cnt10", 32'(br_cnt), 32'd10);
    end
    chk("E_br_sat",    32'(br_cnt), 32'd15);
    chk("E_taken_sat", 32'(taken_cnt), 32'd15);
    chk("E_redirect",  32'(redirect), 32'd1);
    chk("E_target",    br_target, 32'h0000_0D08);
    id_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
